hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised D-stage hazard controller for the 5-stage MIPS pipeline; replaces fixed E/M compare logic.
//  Keeps a DEPTH-entry shift scoreboard of in-flight register writes with self-decrementing Tnew.
//  Owns the mul/div busy timer, a serialising-instruction hold window and a stall-cycle counter.
//  Drives the shared stall to IFU/D_REG/E_REG and per-operand forward-source selects.
// PARAMETERS
//  RN_W        5   register-number width
//  T_W         2   Tuse/Tnew width
//  DEPTH       3   scoreboard slots (slot0=E, slot1=M, slot2=W)
//  MUL_LAT     5   busy cycles after a mult/multu issues
//  DIV_LAT     10  busy cycles after a div/divu issues
//  BLK_CYC     1   stall cycles after a serialising instruction (e.g. bslt) issues; 0 disables
//  CNT_W       32  stall-counter width
// PORTS
//  clk          in   1      clock, rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  d_valid      in   1      D holds a real instruction
//  d_rs, d_rt   in   RN_W   D source register numbers
//  d_tuse_rs/rt in   T_W    D Tuse per source
//  d_wr_en      in   1      D instruction writes a GPR
//  d_wr_num     in   RN_W   D destination register
//  d_tnew       in   T_W    Tnew of D instruction on entering E
//  d_md_start   in   1      D is mult/div; d_md_div selects DIV_LAT (1) or MUL_LAT (0)
//  d_md_div     in   1      see d_md_start
//  d_md_use     in   1      D is mfhi/mflo/mthi/mtlo/mult/div (needs HI/LO unit idle)
//  d_serial     in   1      D is a serialising instruction
//  flush        in   1      kill D this cycle (insert bubble, no scoreboard/timer load)
//  stall        out  1      freeze PC and D_REG, bubble E_REG
//  fwd_sel_rs/rt out $clog2(DEPTH+1)  0=regfile, k=slot k-1 result
//  md_busy      out  1      mul/div timer non-zero
//  stall_cnt    out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//  Reset (async, reset_n=0): all slots invalid, md timer=0, blk timer=0, stall_cnt=0.
//   stall=0, fwd_sel=0, md_busy=0 while in reset.
//  issue = d_valid & ~stall & ~flush.
//  Every edge: slot[i+1] <= slot[i] with tnew saturating-decremented (0 stays 0); slot[DEPTH-1] drops.
//   slot0 <= issue&d_wr_en&(d_wr_num!=0) ? {1,d_wr_num,d_tnew} : invalid bubble.
//  Data hazard, per source s in {rs,rt}, s!=0:
//   hit_i = slot[i].v & slot[i].num==s.
//   Stall if the youngest (lowest i) hit has tuse_s < slot[i].tnew.
//   Older hits are shadowed by the youngest hit.
//  fwd_sel_s = i+1 for youngest hit with tnew==0, else 0 (also 0 when s==0).
//  MD timer: on issue&d_md_start, load DIV_LAT or MUL_LAT; else decrement to 0.
//   md_busy = timer!=0.
//   Stall if d_valid & d_md_use & (md_busy | slot0 holds a just-issued md start).
//   Track that as 1-bit md_pend for one cycle.
//  Serialising: on issue&d_serial, load blk timer with BLK_CYC.
//   Stall every D instruction while blk timer!=0; decrement each cycle.
//  stall = d_valid & (data_rs|data_rt|md_stall|blk_stall); combinational, same-cycle.
//  flush with stall=1: flush wins for the slot0 load (bubble); timers unaffected.
//  stall_cnt += stall each cycle, saturates at all-ones.
//  Simultaneous md load and decrement: load wins.
//  Reset mid-mul/div or mid-hold: timers clear immediately, no residual stall.
//  Widths: tnew/tuse compares are unsigned T_W; timers are $clog2(max(LAT,BLK_CYC)+1) wide.
// STRUCTURE
//  Shared package hazard_pkg: slot record typedef {v,num,tnew}, T_W/RN_W defaults,
//   FWD_RF=0 encoding.
//  One sub-module hs_countdown (load/decrement/zero-flag timer); instantiated for the md and blk timers.
//  Scoreboard shift, hit/priority logic and counter stay in the top module.
// TESTING
//  1. lw $1 (tnew=2) issues; next D addu rs=$1, tuse=0:
//     stall=1 for 2 cycles, then fwd_sel_rs=2 (M slot) or 3 (W slot) with stall=0.
//  2. addu $2 (tnew=1) then beq rs=$2, tuse=0:
//     stall=1 for 1 cycle; next cycle fwd_sel_rs=2, stall=0; rs=$0 never stalls.
//  3. div issued (DIV_LAT=10) then mflo:
//     stall=1 and md_busy=1 for exactly 10 cycles, stall_cnt=10 afterwards.
//  4. Serialising instruction with BLK_CYC=1, any next D:
//     stall exactly 1 cycle; with BLK_CYC=0, no stall.
//  5. Two writers to $3 in E (tnew=0) and M: fwd_sel_rs=1 (youngest wins).
//     flush during a stall gives a bubble in slot0.
//  6. reset_n low mid-mul (timer=3): md_busy=0 and stall=0 immediately.
//     stall_cnt at all-ones stays saturated.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the D-stage hazard controller.
// Slot record, default widths and the forward-select encoding for "no bypass".
package hazard_pkg;

    localparam int HZ_RN_W = 5;
    localparam int HZ_T_W  = 2;
    localparam int FWD_RF  = 0;

    typedef struct packed {
        logic                v;
        logic [HZ_RN_W-1:0]  num;
        logic [HZ_T_W-1:0]   tnew;
    } hz_slot_t;

    function automatic int hz_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hs_countdown.sv
// Loadable down-counter that parks at zero; busy_o is high while the count is non-zero.
// A load in the same cycle as a pending decrement takes priority.
module hs_countdown #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         busy_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard controller: shift scoreboard of in-flight GPR writes, HI/LO busy timer,
// serialising hold window and saturating stall counter; drives stall and bypass selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int RN_W    = HZ_RN_W,
    parameter int T_W     = HZ_T_W,
    parameter int DEPTH   = 3,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int BLK_CYC = 1,
    parameter int CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       d_valid,
    input  logic [RN_W-1:0]            d_rs,
    input  logic [RN_W-1:0]            d_rt,
    input  logic [T_W-1:0]             d_tuse_rs,
    input  logic [T_W-1:0]             d_tuse_rt,
    input  logic                       d_wr_en,
    input  logic [RN_W-1:0]            d_wr_num,
    input  logic [T_W-1:0]             d_tnew,
    input  logic                       d_md_start,
    input  logic                       d_md_div,
    input  logic                       d_md_use,
    input  logic                       d_serial,
    input  logic                       flush,
    output logic                       stall,
    output logic [$clog2(DEPTH+1)-1:0] fwd_sel_rs,
    output logic [$clog2(DEPTH+1)-1:0] fwd_sel_rt,
    output logic                       md_busy,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int FS_W  = $clog2(DEPTH + 1);
    localparam int MD_W  = $clog2(hz_max(hz_max(MUL_LAT, DIV_LAT), 1) + 1);
    localparam int BLK_W = $clog2(hz_max(BLK_CYC, 1) + 1);

    typedef struct packed {
        logic            v;
        logic [RN_W-1:0] num;
        logic [T_W-1:0]  tnew;
    } slot_t;

    typedef struct packed {
        logic            stall;
        logic [FS_W-1:0] fwd;
    } src_res_t;

    slot_t [DEPTH-1:0] slot_q, slot_d;
    logic              md_pend_q, md_pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              issue, md_stall, blk_busy;
    src_res_t          res_rs, res_rt;

    // Youngest matching slot decides both stall and bypass; older matches are shadowed.
    function automatic src_res_t resolve(input slot_t [DEPTH-1:0] sl,
                                         input logic [RN_W-1:0] src,
                                         input logic [T_W-1:0]  tuse);
        src_res_t r;
        logic     found;
        r     = '0;
        found = 1'b0;
        if (src != '0) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && sl[i].v && (sl[i].num == src)) begin
                    found   = 1'b1;
                    r.stall = (tuse < sl[i].tnew);
                    r.fwd   = (sl[i].tnew == '0) ? FS_W'(i + 1) : FS_W'(FWD_RF);
                end
            end
        end
        return r;
    endfunction

    assign res_rs   = resolve(slot_q, d_rs, d_tuse_rs);
    assign res_rt   = resolve(slot_q, d_rt, d_tuse_rt);
    assign md_stall = d_md_use & (md_busy | md_pend_q);
    assign stall    = d_valid & (res_rs.stall | res_rt.stall | md_stall | blk_busy);
    assign issue    = d_valid & ~stall & ~flush;

    assign fwd_sel_rs = res_rs.fwd;
    assign fwd_sel_rt = res_rt.fwd;
    assign stall_cnt  = cnt_q;

    always_comb begin
        slot_d = '0;
        if (issue && d_wr_en && (d_wr_num != '0)) begin
            slot_d[0].v    = 1'b1;
            slot_d[0].num  = d_wr_num;
            slot_d[0].tnew = d_tnew;
        end
        for (int i = 1; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i-1];
            if (slot_q[i-1].tnew != '0)
                slot_d[i].tnew = slot_q[i-1].tnew - T_W'(1);
        end
    end

    always_comb begin
        md_pend_d = issue & d_md_start;
        cnt_d     = cnt_q;
        if (stall && !(&cnt_q))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q    <= '0;
            md_pend_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            slot_q    <= slot_d;
            md_pend_q <= md_pend_d;
            cnt_q     <= cnt_d;
        end
    end

    hs_countdown #(.W(MD_W)) u_md_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (issue & d_md_start),
        .load_val_i (d_md_div ? MD_W'(DIV_LAT) : MD_W'(MUL_LAT)),
        .busy_o     (md_busy)
    );

    hs_countdown #(.W(BLK_W)) u_blk_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (issue & d_serial),
        .load_val_i (BLK_W'(BLK_CYC)),
        .busy_o     (blk_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default instance plus a BLK_CYC=0, CNT_W=4 instance
// sharing the same D-stage stimulus; expectations are queued on drive and checked mid-cycle.
module tb_hazard_scoreboard;

    typedef struct packed {
        logic       v;
        logic [4:0] rs, rt;
        logic [1:0] trs, trt;
        logic       wen;
        logic [4:0] wn;
        logic [1:0] tn;
        logic       mds, mdd, mdu, ser, fl;
    } ins_t;

    typedef struct {
        logic       st;
        logic [1:0] frs, frt;
        logic       busy;
        int         cnt;
        logic       st2;
        int         cnt2;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        d_valid, d_wr_en, d_md_start, d_md_div, d_md_use, d_serial, flush;
    logic [4:0]  d_rs, d_rt, d_wr_num;
    logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
    logic        stall, md_busy, stall2, md_busy2;
    logic [1:0]  frs, frt, frs2, frt2;
    logic [31:0] cnt;
    logic [3:0]  cnt2;

    int   tests = 0;
    int   fails = 0;
    int   exp_cnt = 0;
    int   exp_cnt2 = 0;
    exp_t sb[$];
    ins_t x;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset_n(reset_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wr_en(d_wr_en), .d_wr_num(d_wr_num),
        .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
        .d_serial(d_serial), .flush(flush), .stall(stall), .fwd_sel_rs(frs), .fwd_sel_rt(frt),
        .md_busy(md_busy), .stall_cnt(cnt)
    );

    hazard_scoreboard #(.BLK_CYC(0), .CNT_W(4)) dut2 (
        .clk(clk), .reset_n(reset_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wr_en(d_wr_en), .d_wr_num(d_wr_num),
        .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
        .d_serial(d_serial), .flush(flush), .stall(stall2), .fwd_sel_rs(frs2), .fwd_sel_rt(frt2),
        .md_busy(md_busy2), .stall_cnt(cnt2)
    );

    function automatic ins_t mk(input int rs, input int rt, input int trs, input int trt,
                                input bit wen, input int wn, input int tn);
        ins_t m;
        m     = '0;
        m.v   = 1'b1;
        m.rs  = 5'(rs);
        m.rt  = 5'(rt);
        m.trs = 2'(trs);
        m.trt = 2'(trt);
        m.wen = wen;
        m.wn  = 5'(wn);
        m.tn  = 2'(tn);
        return m;
    endfunction

    task automatic drive(input ins_t m);
        d_valid = m.v;     d_rs = m.rs;        d_rt = m.rt;
        d_tuse_rs = m.trs; d_tuse_rt = m.trt;  d_wr_en = m.wen;
        d_wr_num = m.wn;   d_tnew = m.tn;      d_md_start = m.mds;
        d_md_div = m.mdd;  d_md_use = m.mdu;   d_serial = m.ser;
        flush = m.fl;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        assert (act === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, expv);
        end
    endtask

    task automatic step(input ins_t m, input logic e_st, input logic [1:0] e_frs,
                        input logic [1:0] e_frt, input logic e_busy, input logic e_st2);
        exp_t e;
        @(posedge clk);
        #1;
        drive(m);
        e.st = e_st; e.frs = e_frs; e.frt = e_frt; e.busy = e_busy;
        e.cnt = exp_cnt; e.st2 = e_st2; e.cnt2 = exp_cnt2;
        sb.push_back(e);
        if (e_st) exp_cnt++;
        if (e_st2 && exp_cnt2 != 15) exp_cnt2++;
        @(negedge clk);
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL scoreboard: observed empty queue expected one entry");
        end else begin
            e = sb.pop_front();
            chk("stall", 32'(stall), 32'(e.st));
            chk("fwd_rs", 32'(frs), 32'(e.frs));
            chk("fwd_rt", 32'(frt), 32'(e.frt));
            chk("md_busy", 32'(md_busy), 32'(e.busy));
            chk("stall_cnt", cnt, 32'(e.cnt));
            chk("stall_noblk", 32'(stall2), 32'(e.st2));
            chk("stall_cnt_sat", 32'(cnt2), 32'(e.cnt2));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Outputs stay quiet in reset even with a demanding D instruction present.
        x = mk(1, 2, 0, 0, 1, 3, 1);
        x.mdu = 1'b1;
        drive(x);
        #3;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_fwd_rs", 32'(frs), 0);
        chk("rst_fwd_rt", 32'(frt), 0);
        chk("rst_md_busy", 32'(md_busy), 0);
        chk("rst_cnt", cnt, 0);
        drive('0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // lw $1 (tnew=2) then addu rs=$1: two stalls, then bypass from W
        step(mk(0, 0, 0, 0, 1, 1, 2), 0, 0, 0, 0, 0);
        x = mk(1, 0, 0, 0, 1, 4, 1);
        step(x, 1, 0, 0, 0, 1);
        step(x, 1, 0, 0, 0, 1);
        step(x, 0, 3, 0, 0, 0);

        // addu $2 (tnew=1) then beq rs=$2: one stall, then bypass from M
        step(mk(0, 0, 0, 0, 1, 2, 1), 0, 0, 0, 0, 0);
        x = mk(2, 0, 0, 0, 0, 0, 0);
        step(x, 1, 0, 0, 0, 1);
        step(x, 0, 2, 0, 0, 0);
        step(mk(0, 0, 0, 0, 1, 0, 1), 0, 0, 0, 0, 0);

        // rt path, tuse equal to tnew does not stall
        step(mk(0, 0, 0, 0, 1, 5, 2), 0, 0, 0, 0, 0);
        x = mk(0, 5, 0, 1, 0, 0, 0);
        step(x, 1, 0, 0, 0, 1);
        step(x, 0, 0, 0, 0, 0);

        // div then mflo: ten busy stall cycles
        x = mk(0, 0, 0, 0, 0, 0, 0);
        x.mds = 1'b1; x.mdd = 1'b1; x.mdu = 1'b1;
        step(x, 0, 0, 0, 0, 0);
        x = mk(0, 0, 0, 0, 1, 6, 1);
        x.mdu = 1'b1;
        for (int k = 0; k < 10; k++) step(x, 1, 0, 0, 1, 1);
        step(x, 0, 0, 0, 0, 0);

        // serialising instruction: one hold cycle, none when BLK_CYC=0
        x = mk(0, 0, 0, 0, 0, 0, 0);
        x.ser = 1'b1;
        step(x, 0, 0, 0, 0, 0);
        x = mk(0, 0, 0, 0, 0, 0, 0);
        step(x, 1, 0, 0, 0, 0);
        step(x, 0, 0, 0, 0, 0);

        // two writers of $3: the younger (tnew=0) shadows the older lw
        step(mk(0, 0, 0, 0, 1, 3, 2), 0, 0, 0, 0, 0);
        step(mk(0, 0, 0, 0, 1, 3, 0), 0, 0, 0, 0, 0);
        step(mk(3, 3, 0, 0, 0, 0, 0), 0, 1, 1, 0, 0);

        // flush during a stall, then a flushed writer leaves no trace
        step(mk(0, 0, 0, 0, 1, 7, 2), 0, 0, 0, 0, 0);
        x = mk(7, 0, 0, 0, 0, 0, 0);
        x.fl = 1'b1;
        step(x, 1, 0, 0, 0, 1);
        x.fl = 1'b0;
        step(x, 1, 0, 0, 0, 1);
        step(x, 0, 3, 0, 0, 0);
        x = mk(0, 0, 0, 0, 1, 8, 1);
        x.fl = 1'b1;
        step(x, 0, 0, 0, 0, 0);
        step(mk(8, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0);

        // mult then mfhi, reset while the timer reads 3
        x = mk(0, 0, 0, 0, 0, 0, 0);
        x.mds = 1'b1; x.mdu = 1'b1;
        step(x, 0, 0, 0, 0, 0);
        x.mds = 1'b0;
        for (int k = 0; k < 3; k++) step(x, 1, 0, 0, 1, 1);
        reset_n = 1'b0;
        #1;
        chk("midmul_md_busy", 32'(md_busy), 0);
        chk("midmul_stall", 32'(stall), 0);
        chk("midmul_cnt", cnt, 0);
        chk("midmul_cnt_sat", 32'(cnt2), 0);
        exp_cnt = 0;
        exp_cnt2 = 0;
        @(negedge clk);
        reset_n = 1'b1;
        step(x, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
